// File: rtl/pwm_duty_decoder_if.sv
// PWM decoder bus: raw PWM line and enable in, decoded duty and status flags out.
interface pwm_duty_decoder_if #(
  parameter int WIDTH = 10
);
  logic             pwmIn;
  logic             enable;
  logic [WIDTH-1:0] duty;
  logic             dutyValid;
  logic             signalLost;
  logic             periodErr;

  modport master (
    output pwmIn,
    output enable,
    input  duty,
    input  dutyValid,
    input  signalLost,
    input  periodErr
  );

  modport slave (
    input  pwmIn,
    input  enable,
    output duty,
    output dutyValid,
    output signalLost,
    output periodErr
  );
endinterface

// File: rtl/pwm_duty_decoder.sv
// Measures high time and period of an asynchronous PWM line and reports the duty per frame.
// Optional glitch filter on the synchronized level: define PWM_DECODER_GLITCH_FILTER_EN.
module pwm_duty_decoder #(
  parameter int WIDTH   = 10,
  parameter int PERIOD  = 1024,
  parameter int TOL     = 8,
  parameter int TIMEOUT = 2048
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  , parameter int FILTER_LEN = 4
`endif
) (
  input  logic               c50M,
  input  logic               reset_n,
  pwm_duty_decoder_if.slave  bus
);

  localparam int                CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     LP_TIMEOUT = CW'(TIMEOUT);
  localparam logic [CW-1:0]     LP_PERIOD  = CW'(PERIOD);
  localparam logic [CW-1:0]     LP_TOL     = CW'(TOL);
  localparam logic [CW-1:0]     LP_ONE     = CW'(1);
  localparam logic [CW-1:0]     LP_DMAX_C  = CW'((2 ** WIDTH) - 1);
  localparam logic [WIDTH-1:0]  LP_DMAX    = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    HIGH    = 2'd1,
    LOW     = 2'd2
  } state_t;

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             w_lvl;
  logic             w_rise;
  logic             w_fall;
  logic [CW-1:0]    r_period_cnt;
  logic [CW-1:0]    r_high_cnt;
  logic [CW-1:0]    w_dev;
  logic [WIDTH-1:0] w_duty_meas;
  logic             w_take_to;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] w_duty_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_lost;
  logic             w_lost_nxt;
  logic             r_perr;
  logic             w_perr_nxt;
  logic             r_to_done;
  logic             w_to_done_nxt;

  // Two-flop synchronizer, plus the delayed level copy used for edge detection
  always_ff @(posedge c50M or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.pwmIn;
      r_s2 <= r_s1;
      r_s3 <= w_lvl;
    end
  end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int             FW       = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0]  LP_FLAST = FW'(FILTER_LEN - 1);

  logic          r_filt;
  logic [FW-1:0] r_fcnt;

  // Level filter: a new level is adopted only after FILTER_LEN consecutive samples agree
  always_ff @(posedge c50M or negedge reset_n) begin
    if (!reset_n) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (r_s2 == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == LP_FLAST) begin
      r_filt <= r_s2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + FW'(1);
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = r_s2;
`endif

  assign w_rise = w_lvl & ~r_s3;
  assign w_fall = ~w_lvl & r_s3;

  // Period and high-time counters: reload on rise, otherwise count and saturate at TIMEOUT
  always_ff @(posedge c50M or negedge reset_n) begin
    if (!reset_n) begin
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
    end else if (!bus.enable) begin
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
    end else if (w_rise) begin
      r_period_cnt <= LP_ONE;
      r_high_cnt   <= LP_ONE;
    end else begin
      if (r_period_cnt != LP_TIMEOUT) begin
        r_period_cnt <= r_period_cnt + LP_ONE;
      end else begin
        r_period_cnt <= r_period_cnt;
      end
      if (w_lvl && (r_high_cnt != LP_TIMEOUT)) begin
        r_high_cnt <= r_high_cnt + LP_ONE;
      end else begin
        r_high_cnt <= r_high_cnt;
      end
    end
  end

  assign w_dev       = (r_period_cnt >= LP_PERIOD) ? (r_period_cnt - LP_PERIOD)
                                                   : (LP_PERIOD - r_period_cnt);
  assign w_duty_meas = (r_high_cnt > LP_DMAX_C) ? LP_DMAX : r_high_cnt[WIDTH-1:0];

  // A rise always wins over a coincident timeout; ACQUIRE fires its timeout only once per entry
  assign w_take_to = bus.enable && !w_rise && (r_period_cnt == LP_TIMEOUT) &&
                     ((r_state != ACQUIRE) || !r_to_done);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_duty_nxt    = r_duty;
    w_valid_nxt   = 1'b0;
    w_lost_nxt    = r_lost;
    w_perr_nxt    = r_perr;
    w_to_done_nxt = r_to_done;
    if (!bus.enable) begin
      w_state_nxt   = ACQUIRE;
      w_to_done_nxt = 1'b0;
    end else if (w_take_to) begin
      w_state_nxt   = ACQUIRE;
      w_duty_nxt    = w_lvl ? LP_DMAX : {WIDTH{1'b0}};
      w_valid_nxt   = 1'b1;
      w_lost_nxt    = 1'b1;
      w_to_done_nxt = 1'b1;
    end else begin
      case (r_state)
        ACQUIRE: begin
          if (w_rise) begin
            w_state_nxt = HIGH;
          end else begin
            w_state_nxt = ACQUIRE;
          end
        end
        HIGH: begin
          if (w_fall) begin
            w_state_nxt = LOW;
          end else begin
            w_state_nxt = HIGH;
          end
        end
        LOW: begin
          if (w_rise) begin
            w_state_nxt = HIGH;
            if (w_dev <= LP_TOL) begin
              w_duty_nxt  = w_duty_meas;
              w_valid_nxt = 1'b1;
              w_lost_nxt  = 1'b0;
              w_perr_nxt  = 1'b0;
            end else begin
              w_perr_nxt  = 1'b1;
            end
          end else begin
            w_state_nxt = LOW;
          end
        end
        default: begin
          w_state_nxt = ACQUIRE;
        end
      endcase
    end
  end

  // State register and registered outputs
  always_ff @(posedge c50M or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ACQUIRE;
      r_duty    <= '0;
      r_valid   <= 1'b0;
      r_lost    <= 1'b1;
      r_perr    <= 1'b0;
      r_to_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_duty    <= w_duty_nxt;
      r_valid   <= w_valid_nxt;
      r_lost    <= w_lost_nxt;
      r_perr    <= w_perr_nxt;
      r_to_done <= w_to_done_nxt;
    end
  end

  assign bus.duty       = r_duty;
  assign bus.dutyValid  = r_valid;
  assign bus.signalLost = r_lost;
  assign bus.periodErr  = r_perr;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: strobes are scored against a queue of expected duty/cycle pairs.
module tb_pwm_duty_decoder;

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int LAT  = 7;
  localparam int B_LO = 4;
`else
  localparam int LAT  = 3;
  localparam int B_LO = 1;
`endif
  localparam int B_HI = 1024 - B_LO;

  typedef struct {
    int duty;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   cyc;
  exp_t exp_q[$];

  pwm_duty_decoder_if #(.WIDTH(10)) bus ();

  pwm_duty_decoder dut (
    .c50M    (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame starting with a rise; the rise completes the previous frame
  task automatic frame(input int hi, input int lo, input bit exp_on, input int exp_duty);
    bus.pwmIn = 1'b1;
    if (exp_on) exp_q.push_back('{exp_duty, cyc + LAT});
    cycles(hi);
    bus.pwmIn = 1'b0;
    cycles(lo);
  endtask

  // 512-high frame with a 2-cycle low glitch inside the high phase
  task automatic gframe(input bit exp_on, input int exp_duty);
    bus.pwmIn = 1'b1;
    if (exp_on) exp_q.push_back('{exp_duty, cyc + LAT});
    cycles(200);
    bus.pwmIn = 1'b0;
    cycles(2);
    bus.pwmIn = 1'b1;
    cycles(310);
    bus.pwmIn = 1'b0;
    cycles(512);
  endtask

  task automatic flags(input string tag, input int d, input bit lost, input bit perr);
    chk({tag, "_duty"}, 32'(bus.duty), d);
    chk({tag, "_lost"}, 32'(bus.signalLost), 32'(lost));
    chk({tag, "_perr"}, 32'(bus.periodErr), 32'(perr));
  endtask

  // Strobe monitor: every dutyValid pulse must match the head of the scoreboard
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.dutyValid === 1'b1) begin
      exp_t e;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("strobe_duty", 32'(bus.duty), e.duty);
        chk("strobe_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    bus.pwmIn  = 1'b0;
    bus.enable = 1'b1;
    cycles(3);
    chk("rst_valid", 32'(bus.dutyValid), 32'd0);
    flags("rst", 0, 1'b1, 1'b0);
    rst_n = 1'b1;

    // 25% duty, nominal period
    frame(256, 768, 1'b0, 0);
    frame(256, 768, 1'b1, 256);
    flags("a_first", 256, 1'b0, 1'b0);
    repeat (3) frame(256, 768, 1'b1, 256);
    flags("a_end", 256, 1'b0, 1'b0);

    // near-100% duty, then line stuck high
    frame(B_HI, B_LO, 1'b1, 256);
    frame(B_HI, B_LO, 1'b1, B_HI);
    frame(B_HI, B_LO, 1'b1, B_HI);
    flags("b_full", B_HI, 1'b0, 1'b0);
    bus.pwmIn = 1'b1;
    exp_q.push_back('{B_HI, cyc + LAT});
    exp_q.push_back('{1023, cyc + LAT + 2048});
    cycles(3000);
    flags("b_stuck", 1023, 1'b1, 1'b0);

    // static low line from reset: one timeout strobe, then silence
    rst_n     = 1'b0;
    bus.pwmIn = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    exp_q.push_back('{0, cyc + 2049});
    cycles(2100);
    flags("c_lost", 0, 1'b1, 1'b0);
    cycles(2000);

    // period tolerance: 900 rejected, 1032 accepted, 1033 rejected
    frame(256, 768, 1'b0, 0);
    frame(300, 600, 1'b1, 256);
    frame(300, 600, 1'b0, 0);
    flags("d_900", 256, 1'b0, 1'b1);
    frame(300, 732, 1'b0, 0);
    frame(300, 733, 1'b1, 300);
    flags("d_1032", 300, 1'b0, 1'b0);
    frame(512, 512, 1'b0, 0);
    flags("d_1033", 300, 1'b0, 1'b1);
    frame(512, 512, 1'b1, 512);
    flags("d_back", 512, 1'b0, 1'b0);

    // enable low discards the frame in progress and holds outputs
    bus.enable = 1'b0;
    cycles(50);
    flags("en_off", 512, 1'b0, 1'b0);
    bus.enable = 1'b1;
    frame(256, 768, 1'b0, 0);
    frame(256, 768, 1'b1, 256);

    // glitches inside the high phase
    gframe(1'b1, 256);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    gframe(1'b1, 512);
    gframe(1'b1, 512);
    flags("f_glitch", 512, 1'b0, 1'b0);
    bus.pwmIn = 1'b1;
    exp_q.push_back('{512, cyc + LAT});
`else
    gframe(1'b0, 0);
    gframe(1'b0, 0);
    flags("f_glitch", 256, 1'b0, 1'b1);
    bus.pwmIn = 1'b1;
`endif

    // reset asserted in the middle of a high phase
    cycles(100);
    rst_n = 1'b0;
    #1;
    chk("e_rst_valid", 32'(bus.dutyValid), 32'd0);
    flags("e_rst", 0, 1'b1, 1'b0);
    cycles(2);
    bus.pwmIn = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    frame(256, 768, 1'b0, 0);
    flags("e_one_rise", 0, 1'b1, 1'b0);
    frame(256, 768, 1'b1, 256);
    bus.pwmIn = 1'b1;
    exp_q.push_back('{256, cyc + LAT});
    cycles(20);
    bus.pwmIn = 1'b0;
    cycles(20);
    flags("e_end", 256, 1'b0, 1'b0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
